dcache_miss_ctrl: RTL and testbench

Miss-handling controller for the 4-way data cache, sitting between the tag-compare stage and the PLRU replacement tracker. On a hit it forwards the hit way to the PLRU as an access/update. On a miss it does four things in order:
- picks a victim way (first invalid way, otherwise the PLRU's `lru` output);
- writes the victim back if it is dirty;
- fetches the new line as a burst and drives line-write strobes into the data/tag RAMs;
- reports the victim as the most recent access.

---
 rtl/dcache_miss_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_miss_ctrl
// Purpose  : 4-way D-cache miss handler: victim pick, writeback, burst refill.
// Revision : 1.0
// ============================================================================
module dcache_miss_ctrl #(
  parameter  int ASSOC_NUM  = 4,
  parameter  int LINE_WORDS = 8,
  parameter  int INDEX_W    = 7,
  localparam int WAY_W      = $clog2(ASSOC_NUM),
  localparam int IDX_W      = $clog2(LINE_WORDS),
  localparam int OFF_W      = IDX_W + 2,
  localparam int TAG_W      = 32 - INDEX_W - OFF_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req_valid,
  input  logic [31:0]                req_addr,
  input  logic [ASSOC_NUM-1:0]       hit_way,
  input  logic [ASSOC_NUM-1:0]       way_valid,
  input  logic [ASSOC_NUM-1:0]       way_dirty,
  input  logic [ASSOC_NUM*TAG_W-1:0] way_tag,
  input  logic [WAY_W-1:0]           lru,
  output logic [ASSOC_NUM-1:0]       plru_access,
  output logic                       plru_update,
  output logic                       stall,
  output logic [WAY_W-1:0]           victim_way,
  output logic                       wr_req,
  output logic [31:0]                wr_addr,
  input  logic                       wr_rdy,
  output logic                       rd_req,
  output logic [31:0]                rd_addr,
  input  logic                       rd_rdy,
  input  logic                       ret_valid,
  input  logic                       ret_last,
  input  logic [31:0]                ret_data,
  output logic                       refill_we,
  output logic [WAY_W-1:0]           refill_way,
  output logic [IDX_W-1:0]           refill_idx,
  output logic [31:0]                refill_data,
  output logic                       refill_tag_we,
  output logic                       miss_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WB     = 3'd1;
  localparam logic [2:0] S_RREQ   = 3'd2;
  localparam logic [2:0] S_REFILL = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q,  state_d;
  logic [31-OFF_W:0] line_q,   line_d;
  logic [TAG_W-1:0]  tag_q,    tag_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [IDX_W-1:0]  cnt_q,    cnt_d;

  logic [WAY_W-1:0]  sel_way;
  logic              sel_found;
  logic              sel_dirty;
  logic [TAG_W-1:0]  sel_tag;
  logic              is_hit;
  logic              is_miss;
  logic              unused_addr_lo;

  // Byte/word offset of the lookup address never leaves this block.
  assign unused_addr_lo = ^req_addr[OFF_W-1:0];

  assign is_hit  = req_valid &  (|hit_way);
  assign is_miss = req_valid & ~(|hit_way);

  // Lowest-index invalid way wins; fall back to the PLRU choice.
  always_comb begin
    sel_way   = lru;
    sel_found = 1'b0;
    for (int i = 0; i < ASSOC_NUM; i++) begin
      if (!sel_found && !way_valid[i]) begin
        sel_way   = WAY_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign sel_dirty = way_valid[sel_way] & way_dirty[sel_way];
  assign sel_tag   = way_tag[sel_way*TAG_W +: TAG_W];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      tag_q    <= '0;
      victim_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      tag_q    <= tag_d;
      victim_q <= victim_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    tag_d    = tag_q;
    victim_d = victim_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (is_miss) begin
          line_d   = req_addr[31:OFF_W];
          tag_d    = sel_tag;
          victim_d = sel_way;
          state_d  = sel_dirty ? S_WB : S_RREQ;
        end
      end
      S_WB: begin
        if (wr_rdy) state_d = S_RREQ;
      end
      S_RREQ: begin
        if (rd_rdy) begin
          state_d = S_REFILL;
          cnt_d   = '0;
        end
      end
      S_REFILL: begin
        if (ret_valid) begin
          cnt_d = cnt_q + IDX_W'(1);
          // Line completion follows the return channel, not the beat count.
          if (ret_last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    plru_access   = '0;
    plru_update   = 1'b0;
    wr_req        = 1'b0;
    wr_addr       = '0;
    rd_req        = 1'b0;
    rd_addr       = '0;
    refill_we     = 1'b0;
    refill_way    = '0;
    refill_idx    = '0;
    refill_data   = '0;
    refill_tag_we = 1'b0;
    miss_done     = 1'b0;
    stall         = (state_q != S_IDLE);
    victim_way    = victim_q;
    case (state_q)
      S_IDLE: begin
        if (is_hit) begin
          plru_update = 1'b1;
          plru_access = hit_way;
        end
      end
      S_WB: begin
        wr_req  = 1'b1;
        wr_addr = {tag_q, line_q[INDEX_W-1:0], {OFF_W{1'b0}}};
      end
      S_RREQ: begin
        rd_req  = 1'b1;
        rd_addr = {line_q, {OFF_W{1'b0}}};
      end
      S_REFILL: begin
        if (ret_valid) begin
          refill_we     = 1'b1;
          refill_way    = victim_q;
          refill_idx    = cnt_q;
          refill_data   = ret_data;
          refill_tag_we = ret_last;
        end
      end
      S_DONE: begin
        plru_update = 1'b1;
        plru_access = ASSOC_NUM'(1) << victim_q;
        miss_done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_miss_ctrl
// Purpose  : Directed + randomized bench with a transaction-level miss model.
// Revision : 1.0
// ============================================================================
module tb_dcache_miss_ctrl;
  localparam int ASSOC_NUM  = 4;
  localparam int LINE_WORDS = 8;
  localparam int INDEX_W    = 7;
  localparam int WAY_W      = 2;
  localparam int IDX_W      = 3;
  localparam int OFF_W      = 5;
  localparam int TAG_W      = 20;

  logic                       clk = 1'b0;
  logic                       resetn;
  logic                       req_valid;
  logic [31:0]                req_addr;
  logic [ASSOC_NUM-1:0]       hit_way, way_valid, way_dirty;
  logic [ASSOC_NUM*TAG_W-1:0] way_tag;
  logic [WAY_W-1:0]           lru;
  logic [ASSOC_NUM-1:0]       plru_access;
  logic                       plru_update, stall;
  logic [WAY_W-1:0]           victim_way;
  logic                       wr_req, wr_rdy, rd_req, rd_rdy;
  logic [31:0]                wr_addr, rd_addr;
  logic                       ret_valid, ret_last;
  logic [31:0]                ret_data;
  logic                       refill_we, refill_tag_we, miss_done;
  logic [WAY_W-1:0]           refill_way;
  logic [IDX_W-1:0]           refill_idx;
  logic [31:0]                refill_data;

  int vectors     = 0;
  int miscompares = 0;

  dcache_miss_ctrl #(.ASSOC_NUM(ASSOC_NUM), .LINE_WORDS(LINE_WORDS), .INDEX_W(INDEX_W)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
    .hit_way(hit_way), .way_valid(way_valid), .way_dirty(way_dirty), .way_tag(way_tag),
    .lru(lru), .plru_access(plru_access), .plru_update(plru_update), .stall(stall),
    .victim_way(victim_way), .wr_req(wr_req), .wr_addr(wr_addr), .wr_rdy(wr_rdy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
    .ret_last(ret_last), .ret_data(ret_data), .refill_we(refill_we),
    .refill_way(refill_way), .refill_idx(refill_idx), .refill_data(refill_data),
    .refill_tag_we(refill_tag_we), .miss_done(miss_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Miss model: pending-phase flags describing what the controller owes.
  logic        m_live = 1'b0;
  logic        m_wb = 1'b0, m_rd = 1'b0, m_fill = 1'b0, m_done = 1'b0;
  int          m_beat = 0;
  int          m_victim = 0;
  logic [31:0] m_line = '0, m_wb_addr = '0;

  always @(negedge clk) begin
    logic        idle, hit, beat;
    int          v;
    logic [79:0] sh;
    logic [31:0] tag;
    idle = !(m_wb || m_rd || m_fill || m_done);
    hit  = idle && req_valid && (hit_way != 0);
    beat = m_fill && ret_valid;
    if (m_live) begin
      chk("plru_update", 32'(plru_update), 32'(hit || m_done));
      chk("plru_access", 32'(plru_access), m_done ? (32'd1 << m_victim) : (hit ? 32'(hit_way) : 32'd0));
      chk("stall",       32'(stall),       32'(!idle));
      chk("victim_way",  32'(victim_way),  32'(m_victim));
      chk("wr_req",      32'(wr_req),      32'(m_wb));
      chk("wr_addr",     wr_addr,          m_wb ? m_wb_addr : 32'd0);
      chk("rd_req",      32'(rd_req),      32'(m_rd));
      chk("rd_addr",     rd_addr,          m_rd ? m_line : 32'd0);
      chk("refill_we",   32'(refill_we),   32'(beat));
      chk("refill_way",  32'(refill_way),  beat ? 32'(m_victim) : 32'd0);
      chk("refill_idx",  32'(refill_idx),  beat ? 32'(m_beat) : 32'd0);
      chk("refill_data", refill_data,      beat ? ret_data : 32'd0);
      chk("refill_tag_we", 32'(refill_tag_we), 32'(beat && ret_last));
      chk("miss_done",   32'(miss_done),   32'(m_done));
    end
    if (!resetn) begin
      m_live = 1'b1;
      m_wb = 0; m_rd = 0; m_fill = 0; m_done = 0;
      m_beat = 0; m_victim = 0; m_line = 0; m_wb_addr = 0;
    end else if (idle) begin
      if (req_valid && hit_way == 0) begin
        v = int'(lru);
        for (int i = ASSOC_NUM - 1; i >= 0; i--) if (!way_valid[i]) v = i;
        sh        = way_tag >> (v * TAG_W);
        tag       = 32'(sh[TAG_W-1:0]);
        m_victim  = v;
        m_line    = req_addr - (req_addr % (32'd1 << OFF_W));
        m_wb_addr = (tag << (INDEX_W + OFF_W)) + (req_addr % (32'd1 << (INDEX_W + OFF_W)))
                    - (req_addr % (32'd1 << OFF_W));
        m_wb = way_valid[v] && way_dirty[v];
        m_rd = !m_wb;
      end
    end else if (m_wb) begin
      if (wr_rdy) begin m_wb = 0; m_rd = 1; end
    end else if (m_rd) begin
      if (rd_rdy) begin m_rd = 0; m_fill = 1; m_beat = 0; end
    end else if (m_fill) begin
      if (ret_valid) begin
        m_beat = (m_beat + 1) % LINE_WORDS;
        if (ret_last) begin m_fill = 0; m_done = 1; end
      end
    end else begin
      m_done = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; hit_way = 0; wr_rdy = 0; rd_rdy = 0; ret_valid = 0; ret_last = 0;
  endtask

  task automatic refill_line(input int gap_before, input int way);
    for (int b = 0; b < LINE_WORDS; b++) begin
      if (b == gap_before) begin
        ret_valid = 0; ret_last = 0;
        #2 chk("gap_refill_we", 32'(refill_we), 32'd0);
        cyc();
      end
      ret_valid = 1; ret_last = (b == LINE_WORDS - 1); ret_data = $urandom;
      #2;
      chk("beat_we",     32'(refill_we),     32'd1);
      chk("beat_idx",    32'(refill_idx),    32'(b));
      chk("beat_way",    32'(refill_way),    32'(way));
      chk("beat_data",   refill_data,        ret_data);
      chk("beat_tag_we", 32'(refill_tag_we), 32'(b == LINE_WORDS - 1));
      cyc();
    end
    ret_valid = 0; ret_last = 0;
    #2;
    chk("done_pulse",  32'(miss_done),   32'd1);
    chk("done_access", 32'(plru_access), 32'd1 << way);
    chk("done_update", 32'(plru_update), 32'd1);
    chk("done_stall",  32'(stall),       32'd1);
    cyc();
    #2 chk("stall_after_done", 32'(stall), 32'd0);
  endtask

  initial begin
    idle_inputs();
    resetn = 0; req_addr = 0; way_valid = 0; way_dirty = 0; way_tag = 0; lru = 0; ret_data = 0;
    cyc(); cyc();
    resetn = 1;
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_victim", 32'(victim_way), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_plru_update", 32'(plru_update), 32'd0);

    req_valid = 1; hit_way = 4'b0100;
    #2;
    chk("hit_update", 32'(plru_update), 32'd1);
    chk("hit_access", 32'(plru_access), 32'h4);
    chk("hit_stall",  32'(stall),       32'd0);
    cyc(); idle_inputs();

    // Invalid way 2 wins over lru=0; clean victim goes straight to refill request.
    req_valid = 1; way_valid = 4'b1011; way_dirty = 4'b1111; lru = 0; req_addr = 32'h1234_5678;
    #2 chk("miss_no_update", 32'(plru_update), 32'd0);
    cyc(); idle_inputs();
    #2;
    chk("m1_stall",   32'(stall),      32'd1);
    chk("m1_victim",  32'(victim_way), 32'd2);
    chk("m1_wr_req",  32'(wr_req),     32'd0);
    chk("m1_rd_req",  32'(rd_req),     32'd1);
    chk("m1_rd_addr", rd_addr,         32'h1234_5660);
    rd_rdy = 1; cyc(); rd_rdy = 0;
    refill_line(LINE_WORDS, 2);
    cyc();

    // Dirty LRU victim 3, writeback accepted after three wait cycles.
    req_valid = 1; way_valid = 4'hF; way_dirty = 4'b1000; lru = 3; req_addr = 32'h0000_0F80;
    way_tag = {20'hABCDE, 20'h11111, 20'h22222, 20'h33333};
    cyc(); idle_inputs();
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("m2_wr_req",  32'(wr_req), 32'd1);
      chk("m2_wr_addr", wr_addr,     32'hABCD_EF80);
      chk("m2_rd_req",  32'(rd_req), 32'd0);
      if (k == 3) wr_rdy = 1;
      cyc();
    end
    wr_rdy = 0;
    #2;
    chk("m2_wr_req_off", 32'(wr_req),     32'd0);
    chk("m2_rd_req",     32'(rd_req),     32'd1);
    chk("m2_rd_addr",    rd_addr,         32'h0000_0F80);
    chk("m2_victim",     32'(victim_way), 32'd3);
    rd_rdy = 1; cyc(); rd_rdy = 0;
    refill_line(4, 3);
    cyc();

    // Reset in the middle of a refill.
    req_valid = 1; way_valid = 4'hF; way_dirty = 4'h0; lru = 1; req_addr = $urandom;
    cyc(); idle_inputs();
    #2 chk("m3_rd_req", 32'(rd_req), 32'd1);
    rd_rdy = 1; cyc(); rd_rdy = 0;
    for (int b = 0; b < 3; b++) begin
      ret_valid = 1; ret_data = $urandom; cyc();
    end
    ret_valid = 0; resetn = 0;
    cyc();
    resetn = 1;
    #2;
    chk("mr_stall",     32'(stall),       32'd0);
    chk("mr_victim",    32'(victim_way),  32'd0);
    chk("mr_rd_req",    32'(rd_req),      32'd0);
    chk("mr_wr_req",    32'(wr_req),      32'd0);
    chk("mr_refill_we", 32'(refill_we),   32'd0);
    chk("mr_done",      32'(miss_done),   32'd0);
    chk("mr_update",    32'(plru_update), 32'd0);
    cyc();
    req_valid = 1; hit_way = 4'b0010;
    #2;
    chk("post_rst_hit_update", 32'(plru_update), 32'd1);
    chk("post_rst_hit_access", 32'(plru_access), 32'h2);
    cyc(); idle_inputs();

    // Randomized traffic; the negedge model checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      resetn    = ($urandom_range(0, 299) != 0);
      req_valid = $urandom_range(0, 1);
      hit_way   = ($urandom_range(0, 1) != 0) ? 4'(0) : 4'($urandom);
      way_valid = 4'($urandom | $urandom);
      way_dirty = 4'($urandom);
      way_tag   = {$urandom, $urandom, $urandom};
      lru       = 2'($urandom);
      req_addr  = $urandom;
      wr_rdy    = ($urandom_range(0, 2) == 0);
      rd_rdy    = ($urandom_range(0, 2) == 0);
      ret_valid = $urandom_range(0, 1);
      ret_data  = $urandom;
      ret_last  = ret_valid && ((m_fill && m_beat == LINE_WORDS - 1) || $urandom_range(0, 15) == 0);
      cyc();
    end
    resetn = 1; idle_inputs();
    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
